// File: rtl/operand_register_multibyte.sv
`default_nettype none
// ============================================================================
// Module   : operand_register_multibyte
// Brief    : Assembles a multi-byte operand from successive data-bus bytes.
//            Tracks progress with a byte counter and a valid flag, and
//            zero-extends operands that are terminated early with L_LAST.
//            Drives the ALU (low byte), the PC (full operand) and a
//            byte-selectable bus readback.
// Revision : 1.0 - initial release
// ============================================================================
module operand_register_multibyte #(
  parameter int                       BUS_W      = 8,
  parameter int                       BYTES      = 2,
  parameter bit                       BIG_ENDIAN = 1'b0,
  parameter logic [BYTES*BUS_W-1:0]   RESET_VAL  = '0,
  localparam int                      c_OP_W     = BYTES * BUS_W,
  localparam int                      c_SEL_W    = (BYTES > 1) ? $clog2(BYTES) : 1,
  localparam int                      c_CNT_W    = $clog2(BYTES + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [BUS_W-1:0]   dataBusIn,
  input  logic               L_OR,
  input  logic               L_LAST,
  input  logic               CLR_OR,
  input  logic               E_OR,
  input  logic [c_SEL_W-1:0] RD_SEL,
  output logic [BUS_W-1:0]   databusOut,
  output logic [BUS_W-1:0]   toALU,
  output logic [c_OP_W-1:0]  OR_PC,
  output logic               OR_VALID,
  output logic [c_CNT_W-1:0] OR_CNT
);

  // Assembly progress: EMPTY (nothing loaded), FILL (partial), FULL (valid).
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_OP_W-1:0]   r_operand;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_valid;

  int                  w_k;         // index of the byte being loaded
  int                  w_slot;      // destination slot for that byte
  int                  w_new_cnt;   // byte count after this load
  logic                w_done;      // this load completes the operand
  logic [c_OP_W-1:0]   w_base;
  logic [c_OP_W-1:0]   w_loaded;
  logic [c_OP_W-1:0]   w_next_op;
  logic [BUS_W-1:0]    w_rd;

  // Next operand value for a load strobe. A first byte (from EMPTY, or a new
  // operand started from FULL) always starts from an all-zero operand, so the
  // unfilled slots read as zero during FILL and after early completion.
  always_comb begin
    w_k       = (r_state == S_FULL) ? 0 : int'(r_cnt);
    w_slot    = (BIG_ENDIAN != 1'b0) ? (BYTES - 1 - w_k) : w_k;
    w_new_cnt = w_k + 1;
    w_done    = L_LAST || (w_new_cnt == BYTES);
    w_base    = (w_k == 0) ? '0 : r_operand;
    w_loaded  = w_base;
    for (int s = 0; s < BYTES; s++) begin
      if (s == w_slot) begin
        w_loaded[s*BUS_W +: BUS_W] = dataBusIn;
      end
    end
    w_next_op = w_loaded;
    // Big-endian bytes fill from the top slot down; an early finish leaves
    // them high, so shift them into the low slots to get the zero-extended
    // numeric value.
    if ((BIG_ENDIAN != 1'b0) && w_done && (w_new_cnt < BYTES)) begin
      w_next_op = w_loaded >> ((BYTES - w_new_cnt) * BUS_W);
    end
  end

  // Operand/assembly state machine; reset and clear dominate loads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_operand <= RESET_VAL;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_state   <= S_EMPTY;
    end else if (CLR_OR) begin
      r_operand <= RESET_VAL;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_state   <= S_EMPTY;
    end else if (L_OR) begin
      r_operand <= w_next_op;
      r_cnt     <= c_CNT_W'(w_new_cnt);
      if (w_done) begin
        r_valid <= 1'b1;
        r_state <= S_FULL;
      end else begin
        r_valid <= 1'b0;
        r_state <= S_FILL;
      end
    end
  end

  // Byte-selectable readback; disabled or out-of-range selects read zero.
  always_comb begin
    w_rd = '0;
    if (E_OR) begin
      for (int s = 0; s < BYTES; s++) begin
        if (int'(RD_SEL) == s) begin
          w_rd = r_operand[s*BUS_W +: BUS_W];
        end
      end
    end
  end

  assign databusOut = w_rd;
  assign toALU      = r_operand[BUS_W-1:0];
  assign OR_PC      = r_operand;
  assign OR_VALID   = r_valid;
  assign OR_CNT     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_operand_register_multibyte.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_register_multibyte
// Brief    : Self-checking bench: table of directed vectors on a 2-byte
//            little-endian instance, plus hand sequences for big-endian,
//            4-byte, async reset and non-zero reset value instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_register_multibyte;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] dataBusIn = '0;
  logic       L_OR = 1'b0, L_LAST = 1'b0, CLR_OR = 1'b0, E_OR = 1'b0;
  logic       RD_SEL = 1'b0;
  logic [1:0] rd_sel4;

  assign rd_sel4 = {1'b0, RD_SEL};

  always #5 CLK = ~CLK;

  // 2-byte little-endian
  logic [7:0]  le_dbo, le_alu;
  logic [15:0] le_pc;
  logic        le_v;
  logic [1:0]  le_cnt;
  // 2-byte big-endian
  logic [7:0]  be_dbo, be_alu;
  logic [15:0] be_pc;
  logic        be_v;
  logic [1:0]  be_cnt;
  // 4-byte little-endian
  logic [7:0]  w4_dbo, w4_alu;
  logic [31:0] w4_pc;
  logic        w4_v;
  logic [2:0]  w4_cnt;
  // 2-byte with non-zero reset value
  logic [7:0]  rv_dbo, rv_alu;
  logic [15:0] rv_pc;
  logic        rv_v;
  logic [1:0]  rv_cnt;

  operand_register_multibyte #(.BUS_W(8), .BYTES(2), .BIG_ENDIAN(1'b0)) dut_le (
    .CLK(CLK), .RST(RST), .dataBusIn(dataBusIn), .L_OR(L_OR), .L_LAST(L_LAST),
    .CLR_OR(CLR_OR), .E_OR(E_OR), .RD_SEL(RD_SEL), .databusOut(le_dbo),
    .toALU(le_alu), .OR_PC(le_pc), .OR_VALID(le_v), .OR_CNT(le_cnt));

  operand_register_multibyte #(.BUS_W(8), .BYTES(2), .BIG_ENDIAN(1'b1)) dut_be (
    .CLK(CLK), .RST(RST), .dataBusIn(dataBusIn), .L_OR(L_OR), .L_LAST(L_LAST),
    .CLR_OR(CLR_OR), .E_OR(E_OR), .RD_SEL(RD_SEL), .databusOut(be_dbo),
    .toALU(be_alu), .OR_PC(be_pc), .OR_VALID(be_v), .OR_CNT(be_cnt));

  operand_register_multibyte #(.BUS_W(8), .BYTES(4), .BIG_ENDIAN(1'b0)) dut_w4 (
    .CLK(CLK), .RST(RST), .dataBusIn(dataBusIn), .L_OR(L_OR), .L_LAST(L_LAST),
    .CLR_OR(CLR_OR), .E_OR(E_OR), .RD_SEL(rd_sel4), .databusOut(w4_dbo),
    .toALU(w4_alu), .OR_PC(w4_pc), .OR_VALID(w4_v), .OR_CNT(w4_cnt));

  operand_register_multibyte #(.BUS_W(8), .BYTES(2), .BIG_ENDIAN(1'b0),
                               .RESET_VAL(16'hBEEF)) dut_rv (
    .CLK(CLK), .RST(RST), .dataBusIn(dataBusIn), .L_OR(L_OR), .L_LAST(L_LAST),
    .CLR_OR(CLR_OR), .E_OR(E_OR), .RD_SEL(RD_SEL), .databusOut(rv_dbo),
    .toALU(rv_alu), .OR_PC(rv_pc), .OR_VALID(rv_v), .OR_CNT(rv_cnt));

  typedef struct packed {
    logic        rst;
    logic        l;
    logic        last;
    logic        clr;
    logic        e;
    logic        sel;
    logic [7:0]  d;
    logic [15:0] pc;
    logic        v;
    logic [1:0]  cnt;
    logic [7:0]  dbo;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, then sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic l, input logic last, input logic clr,
                      input logic e, input logic sel, input logic [7:0] d);
    @(negedge CLK);
    RST = rst; L_OR = l; L_LAST = last; CLR_OR = clr; E_OR = e; RD_SEL = sel; dataBusIn = d;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //          rst l  last clr e  sel d       pc        v  cnt  dbo
    vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,8'h00, 16'h0000,1'b0,2'd0,8'h00};
    vecs[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h34, 16'h0034,1'b0,2'd1,8'h34};
    vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h12, 16'h1234,1'b1,2'd2,8'h12};
    vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,8'h00, 16'h1234,1'b1,2'd2,8'h34};
    vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,8'h00, 16'h1234,1'b1,2'd2,8'h00};
    vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,8'hAB, 16'h00AB,1'b0,2'd1,8'h00};
    vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,8'hCD, 16'h0000,1'b0,2'd0,8'h00};
    vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,8'h99, 16'h0000,1'b0,2'd0,8'h00};
    vecs[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,8'h7F, 16'h007F,1'b1,2'd1,8'h00};
    vecs[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,8'h11, 16'h0011,1'b0,2'd1,8'h11};
    vecs[10] = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,8'h22, 16'h2211,1'b1,2'd2,8'h22};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,8'h00, 16'h0000,1'b0,2'd0,8'h00};

    // Reset state including a non-zero reset value
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_le_pc", 32'(le_pc), 32'h0000);
    chk("rst_rv_pc", 32'(rv_pc), 32'hBEEF);
    chk("rst_rv_valid", 32'(rv_v), 32'h0);

    // Table-driven vectors on the 2-byte little-endian instance
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst, vecs[i].l, vecs[i].last, vecs[i].clr, vecs[i].e, vecs[i].sel, vecs[i].d);
      chk($sformatf("v%0d_pc", i),    32'(le_pc),  32'(vecs[i].pc));
      chk($sformatf("v%0d_alu", i),   32'(le_alu), 32'(vecs[i].pc[7:0]));
      chk($sformatf("v%0d_valid", i), 32'(le_v),   32'(vecs[i].v));
      chk($sformatf("v%0d_cnt", i),   32'(le_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_dbo", i),   32'(le_dbo), 32'(vecs[i].dbo));
    end

    // Big-endian assembly and early completion
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12);
    chk("be1_pc", 32'(be_pc), 32'h1200);
    chk("be1_cnt", 32'(be_cnt), 32'd1);
    chk("be1_valid", 32'(be_v), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h34);
    chk("be2_pc", 32'(be_pc), 32'h1234);
    chk("be2_valid", 32'(be_v), 32'h1);
    chk("be2_alu", 32'(be_alu), 32'h34);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7F);
    chk("be_last_pc", 32'(be_pc), 32'h007F);
    chk("be_last_valid", 32'(be_v), 32'h1);
    chk("be_last_cnt", 32'(be_cnt), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // 4-byte assembly: valid only after the fourth byte
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    chk("w4_1_cnt", 32'(w4_cnt), 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h02);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h03);
    chk("w4_3_pc", w4_pc, 32'h00030201);
    chk("w4_3_valid", 32'(w4_v), 32'h0);
    chk("w4_3_cnt", 32'(w4_cnt), 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h04);
    chk("w4_4_pc", w4_pc, 32'h04030201);
    chk("w4_4_valid", 32'(w4_v), 32'h1);
    chk("w4_4_cnt", 32'(w4_cnt), 32'd4);
    chk("w4_4_dbo", 32'(w4_dbo), 32'h02);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset mid-assembly, between edges
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
    chk("ar_pre_pc", 32'(le_pc), 32'h0099);
    @(negedge CLK);
    L_OR = 1'b0;
    RST = 1'b1;
    #1;
    chk("ar_pc", 32'(le_pc), 32'h0000);
    chk("ar_alu", 32'(le_alu), 32'h00);
    chk("ar_valid", 32'(le_v), 32'h0);
    chk("ar_cnt", 32'(le_cnt), 32'd0);
    chk("ar_rv_pc", 32'(rv_pc), 32'hBEEF);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
    chk("ar_post_pc", 32'(le_pc), 32'h0055);
    chk("ar_post_cnt", 32'(le_cnt), 32'd1);

    // Non-zero reset value: first byte starts from zero, clear restores it
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01);
    chk("rv_load_pc", 32'(rv_pc), 32'h0001);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
    chk("rv_clr_pc", 32'(rv_pc), 32'hBEEF);
    chk("rv_clr_cnt", 32'(rv_cnt), 32'd0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
